// File: rtl/i2s_pkg.sv
// Shared I2S definitions: channel-select encoding carried on ws and the default sample width.
package i2s_pkg;

  typedef enum logic {
    I2S_CH_LEFT  = 1'b0,
    I2S_CH_RIGHT = 1'b1
  } i2s_ch_e;

  localparam int I2S_DEFAULT_WIDTH = 16;

endpackage

// File: rtl/i2s_clk_edge.sv
// Oversamples the externally supplied I2S bit clock and word select in the clk domain and
// reports sck edges plus word-select transitions seen at sck rising edges.
module i2s_clk_edge
  import i2s_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sck,
  input  logic i_ws,
  output logic o_sck_rise,
  output logic o_sck_fall,
  output logic o_ws_change,
  output logic o_ws_q
);

  logic r_last_sck;
  logic r_last_ws;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_last_sck <= 1'b0;
      r_last_ws  <= 1'b0;
    end else begin
      r_last_sck <= i_sck;
      if (o_sck_rise) begin
        r_last_ws <= i_ws;
      end
    end
  end

  // ws is only meaningful at sck rising edges, so transitions are qualified by the rise
  assign o_sck_rise  = ~r_last_sck & i_sck;
  assign o_sck_fall  = r_last_sck & ~i_sck;
  assign o_ws_change = o_sck_rise & (i_ws != r_last_ws);
  assign o_ws_q      = r_last_ws;

endmodule

// File: rtl/i2s_tx.sv
// Stereo I2S transmitter slaved to external sck/ws; serializes AXI-stream L/R pairs MSB-first.
// Build option I2S_TX_UNDERRUN_REPEAT_EN: on underrun, resend the last consumed pair instead of zeros.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int WIDTH = I2S_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sck,
  input  logic             ws,
  output logic             sd,
  input  logic [WIDTH-1:0] input_l_tdata,
  input  logic [WIDTH-1:0] input_r_tdata,
  input  logic             input_tvalid,
  output logic             input_tready,
  output logic             underrun
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             w_sck_rise;
  logic             w_sck_fall;
  logic             w_ws_change;
  logic             w_ws_q;
  i2s_ch_e          w_new_ch;
  logic             w_left_bnd;
  logic             w_right_bnd;
  logic             w_take;
  logic [WIDTH-1:0] w_uf_l;
  logic [WIDTH-1:0] w_uf_r;

  logic [WIDTH-1:0] r_l_hold;
  logic [WIDTH-1:0] r_r_hold;
  logic             r_hold_valid;
  logic [WIDTH-1:0] r_r_pend;
  logic [WIDTH-1:0] r_sreg;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_sd;
  logic             r_underrun;

  i2s_clk_edge u_clk_edge (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_sck       (sck),
    .i_ws        (ws),
    .o_sck_rise  (w_sck_rise),
    .o_sck_fall  (w_sck_fall),
    .o_ws_change (w_ws_change),
    .o_ws_q      (w_ws_q)
  );

  // On a transition the new word select is simply the complement of the stored one
  assign w_new_ch    = i2s_ch_e'(~w_ws_q);
  assign w_left_bnd  = w_ws_change & (w_new_ch == I2S_CH_LEFT);
  assign w_right_bnd = w_ws_change & (w_new_ch == I2S_CH_RIGHT);
  assign w_take      = input_tvalid & ~r_hold_valid;

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  logic [WIDTH-1:0] r_last_l;
  logic [WIDTH-1:0] r_last_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_l <= '0;
      r_last_r <= '0;
    end else if (w_left_bnd && r_hold_valid) begin
      r_last_l <= r_l_hold;
      r_last_r <= r_r_hold;
    end
  end

  assign w_uf_l = r_last_l;
  assign w_uf_r = r_last_r;
`else
  assign w_uf_l = '0;
  assign w_uf_r = '0;
`endif

  // Holding register: refilled from the stream, drained only at a left boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_l_hold     <= '0;
      r_r_hold     <= '0;
      r_hold_valid <= 1'b0;
    end else if (w_take) begin
      r_l_hold     <= input_l_tdata;
      r_r_hold     <= input_r_tdata;
      r_hold_valid <= 1'b1;
    end else if (w_left_bnd) begin
      r_hold_valid <= 1'b0;
    end
  end

  // Serializer: boundaries reload the shifter even mid-word, which truncates short slots
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_r_pend   <= '0;
      r_sreg     <= '0;
      r_bit_cnt  <= '0;
      r_sd       <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      if (w_left_bnd) begin
        r_bit_cnt <= CNT_W'(WIDTH);
        if (r_hold_valid) begin
          r_sreg   <= r_l_hold;
          r_r_pend <= r_r_hold;
        end else begin
          r_sreg     <= w_uf_l;
          r_r_pend   <= w_uf_r;
          r_underrun <= 1'b1;
        end
      end else if (w_right_bnd) begin
        r_sreg    <= r_r_pend;
        r_bit_cnt <= CNT_W'(WIDTH);
      end else if (w_sck_fall) begin
        if (r_bit_cnt != '0) begin
          r_sd      <= r_sreg[WIDTH-1];
          r_sreg    <= {r_sreg[WIDTH-2:0], 1'b0};
          r_bit_cnt <= r_bit_cnt - CNT_W'(1);
        end else begin
          r_sd <= 1'b0;
        end
      end
    end
  end

  assign sd           = r_sd;
  assign underrun     = r_underrun;
  assign input_tready = ~r_hold_valid;

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: stimulus queues expected slot contents, an sck-rise receiver pops and compares.
module tb_i2s_tx;

  localparam int W     = 16;
  localparam int LIMIT = 2000;

  logic         clk          = 1'b0;
  logic         rst          = 1'b1;
  logic         sck          = 1'b0;
  logic         ws           = 1'b1;
  logic         sd;
  logic [W-1:0] il           = '0;
  logic [W-1:0] ir           = '0;
  logic         input_tvalid = 1'b0;
  logic         input_tready;
  logic         underrun;

  int tests     = 0;
  int fails     = 0;
  int rst_epoch = 0;
  int slot_len  = 16;
  int un_cnt    = 0;
  int tr_cnt    = 0;

  logic [63:0] sb[$];

  always #5 clk = ~clk;

  i2s_tx #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .sck           (sck),
    .ws            (ws),
    .sd            (sd),
    .input_l_tdata (il),
    .input_r_tdata (ir),
    .input_tvalid  (input_tvalid),
    .input_tready  (input_tready),
    .underrun      (underrun)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Receiver: a slot's bits are sampled on the slot_len rises following its ws transition
  logic        armed     = 1'b0;
  logic        prev_ws   = 1'b1;
  int          cnt       = 0;
  int          mon_epoch = 0;
  logic [63:0] acc       = '0;

  always @(posedge sck) begin
    if (mon_epoch != rst_epoch) begin
      armed     = 1'b0;
      cnt       = 0;
      mon_epoch = rst_epoch;
    end
    if (rst) begin
      if (!armed) begin
        if (!ws && prev_ws) begin
          armed = 1'b1;
          cnt   = 0;
          acc   = '0;
        end
      end else begin
        acc = {acc[62:0], sd};
        cnt++;
        if (cnt == slot_len) begin
          if (sb.size() == 0) begin
            check("unexpected_word", acc, 64'hdead_beef_dead_beef);
          end else begin
            check("sd_word", acc, sb.pop_front());
          end
          cnt = 0;
          acc = '0;
        end
      end
    end
    prev_ws = ws;
  end

  logic prev_un = 1'b0;
  logic prev_tr = 1'b1;

  always @(negedge clk) begin
    if (prev_un) check("underrun_width", 64'(underrun), 64'd0);
    if (underrun && !prev_un) un_cnt++;
    if (input_tready && !prev_tr) tr_cnt++;
    prev_un = underrun;
    prev_tr = input_tready;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    rst_epoch++;
    sck = 1'b0;
    ws  = 1'b1;
    input_tvalid = 1'b0;
    #1;
    check("reset_sd", 64'(sd), 64'd0);
    check("reset_tready", 64'(input_tready), 64'd1);
    check("reset_underrun", 64'(underrun), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_pair(input logic [W-1:0] l, input logic [W-1:0] r);
    int n;
    @(negedge clk);
    il = l;
    ir = r;
    input_tvalid = 1'b1;
    n = 0;
    while (!input_tready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", 64'(input_tready), 64'd1);
    @(posedge clk);
    #1;
    input_tvalid = 1'b0;
  endtask

  task automatic bit_period(input logic w);
    sck = 1'b0;
    ws  = w;
    repeat (4) @(negedge clk);
    sck = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // One right-slot lead-in, nf left/right frames, then one trailing rise to clock in the last bit
  task automatic gen(input int nf, input int slot);
    bit_period(1'b1);
    for (int f = 0; f < nf; f++) begin
      for (int b = 0; b < slot; b++) bit_period(1'b0);
      for (int b = 0; b < slot; b++) bit_period(1'b1);
    end
    bit_period(1'b1);
    sck = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int un0;
    int tr0;

    // Basic serialization
    do_reset();
    slot_len = 16;
    un0 = un_cnt;
    push_pair(16'hA5C3, 16'h0F0F);
    check("t1_tready_full", 64'(input_tready), 64'd0);
    sb.push_back(64'hA5C3);
    sb.push_back(64'h0F0F);
    gen(1, 16);
    check("t1_tready_drained", 64'(input_tready), 64'd1);
    check("t1_sb_empty", 64'(sb.size()), 64'd0);
    check("t1_underruns", 64'(un_cnt - un0), 64'd0);

    // Pad bits in 32-bit slots
    do_reset();
    slot_len = 32;
    un0 = un_cnt;
    push_pair(16'hA5C3, 16'h0F0F);
    sb.push_back(64'hA5C3_0000);
    sb.push_back(64'h0F0F_0000);
    gen(1, 32);
    check("t2_sb_empty", 64'(sb.size()), 64'd0);
    check("t2_underruns", 64'(un_cnt - un0), 64'd0);

    // Short 12-bit slots truncate, next frame still carries a fresh pair
    do_reset();
    slot_len = 12;
    un0 = un_cnt;
    push_pair(16'hFFFF, 16'h0F0F);
    sb.push_back(64'hFFF);
    sb.push_back(64'h0F0);
    sb.push_back(64'h123);
    sb.push_back(64'h567);
    fork
      gen(2, 12);
      push_pair(16'h1234, 16'h5678);
    join
    check("t3_sb_empty", 64'(sb.size()), 64'd0);
    check("t3_underruns", 64'(un_cnt - un0), 64'd0);

    // Underrun for two frames
    do_reset();
    slot_len = 16;
    un0 = un_cnt;
    push_pair(16'h1234, 16'h5678);
    sb.push_back(64'h1234);
    sb.push_back(64'h5678);
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    for (int i = 0; i < 2; i++) begin
      sb.push_back(64'h1234);
      sb.push_back(64'h5678);
    end
`else
    for (int i = 0; i < 4; i++) sb.push_back(64'h0);
`endif
    gen(3, 16);
    check("t4_sb_empty", 64'(sb.size()), 64'd0);
    check("t4_underruns", 64'(un_cnt - un0), 64'd2);

    // Backpressure: continuous stream, one pair accepted per frame
    do_reset();
    slot_len = 16;
    un0 = un_cnt;
    push_pair(16'h1000, 16'h2000);
    sb.push_back(64'h1000);
    sb.push_back(64'h2000);
    tr0 = tr_cnt;
    fork
      gen(8, 16);
      begin
        for (int k = 1; k <= 8; k++) begin
          if (k < 8) begin
            sb.push_back(64'(16'h1000 + 16'(k)));
            sb.push_back(64'(16'h2000 + 16'(k)));
          end
          push_pair(16'h1000 + 16'(k), 16'h2000 + 16'(k));
        end
      end
    join
    check("t5_sb_empty", 64'(sb.size()), 64'd0);
    check("t5_tready_rises", 64'(tr_cnt - tr0), 64'd8);
    check("t5_underruns", 64'(un_cnt - un0), 64'd0);

    // Reset in the middle of a left word
    do_reset();
    slot_len = 16;
    un0 = un_cnt;
    push_pair(16'hFFFF, 16'hFFFF);
    fork
      gen(3, 16);
      begin
        repeat (8 * 6 + 2) @(negedge clk);
        check("t6_sd_before_reset", 64'(sd), 64'd1);
        rst = 1'b0;
        rst_epoch++;
        #1;
        check("t6_sd_in_reset", 64'(sd), 64'd0);
        check("t6_tready_in_reset", 64'(input_tready), 64'd1);
        check("t6_underrun_in_reset", 64'(underrun), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sb.push_back(64'h3333);
        sb.push_back(64'h4444);
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
        sb.push_back(64'h3333);
        sb.push_back(64'h4444);
`else
        sb.push_back(64'h0);
        sb.push_back(64'h0);
`endif
        push_pair(16'h3333, 16'h4444);
      end
    join
    check("t6_sb_empty", 64'(sb.size()), 64'd0);
    check("t6_underruns", 64'(un_cnt - un0), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Stereo I2S transmitter: takes left/right sample pairs on an AXI-stream input and serializes them MSB-first onto `sd`, slaved to externally supplied `sck` and `ws`. It is the output-side counterpart of the I2S receive stage and consumes the same stereo stream format (`*_l_tdata`, `*_r_tdata`, a shared `tvalid`/`tready`), so a receive stream can be looped straight back out. All logic runs in the single `clk` domain. `sck` and `ws` are oversampled and edge-detected, so `clk` must run at least 4x `sck`.

## Interface

**Parameters**
- `WIDTH`, default 16: sample width in bits, ≥ 2.

**Ports**
- `clk`  input  1  system clock.
- `rst`  input  1  reset, asynchronous and active-low.
- `sck`  input  1  I2S bit clock, already synchronous to `clk`.
- `ws`  input  1  I2S word select: 0 = left, 1 = right.
- `sd`  output  1  I2S serial data, registered.
- `input_l_tdata`  input  WIDTH  left sample.
- `input_r_tdata`  input  WIDTH  right sample.
- `input_tvalid`  input  1  sample pair valid.
- `input_tready`  output  1  holding register empty.
- `underrun`  output  1  one-`clk` pulse when a frame starts with no pair available.

## Operation

- **Reset values.** `sd`=0, `underrun`=0, `input_tready`=1. The holding register, shift register, bit counter, `last_sck` and `last_ws` all reset to 0. `last_pair` (see Configuration) also resets to 0.
- **Holding register.**
  - One stereo pair, held in `l_hold`, `r_hold` and `hold_valid`.
  - `input_tready` = ~`hold_valid`.
  - On `input_tvalid` & `input_tready`, capture both samples and set `hold_valid`.
- **Rising edge of `sck`** (`~last_sck & sck`):
  - Sample `ws` into `last_ws`.
  - If `ws != last_ws`, this is a word boundary: load `sreg` and set `bit_cnt` = `WIDTH`.
- **Left word boundary** (new `ws`=0):
  - If `hold_valid`: `sreg` ← `l_hold`, `r_pend` ← `r_hold`, clear `hold_valid`.
  - Otherwise, underrun: load the underrun pair (see Configuration) and pulse `underrun`.
- **Right word boundary** (new `ws`=1): `sreg` ← `r_pend`.
- **Falling edge of `sck`** (`last_sck & ~sck`):
  - If `bit_cnt` > 0: `sd` ← `sreg[WIDTH-1]`, shift `sreg` left by 1, decrement `bit_cnt`.
  - Otherwise `sd` ← 0 (pad bits for slots longer than `WIDTH`).
- **Short slot.** A `ws` transition before `WIDTH` bits have been sent truncates the current word; the new word loads immediately.
- **Frame pairing.** A frame is always a left word followed by a right word. A pair is only ever consumed at a left boundary, so a pair captured mid-frame waits for the next left boundary.
- **Startup.** After reset `sd` stays 0 until the first `ws` transition. If the first boundary seen is a right boundary, it transmits `r_pend` (0).
- **Simultaneous events.** An input capture in the same `clk` cycle as a left-boundary load is not possible, because `tready` is 0 whenever `hold_valid` is 1. A capture landing in the cycle right after the load is accepted normally.
- **Reset mid-word.** Asserting reset mid-word aborts the word immediately: `sd` goes to 0 asynchronously and the pending pair is discarded.

## Timing

- `sd` changes one `clk` after the cycle in which the `sck` falling edge is seen. It is therefore stable well before the next `sck` rise.
- The MSB is driven on the first `sck` falling edge after the `sck` rising edge that detected the `ws` change. This gives the standard I2S one-bit delay after `ws`.
- **Throughput.** One pair per `ws` period. Input latency from acceptance to MSB on `sd` is at most one frame plus one `sck` period.
- `underrun` is asserted in the `clk` cycle after the detecting `sck` rising edge, for exactly one cycle.

## Configuration

- Macro `I2S_TX_UNDERRUN_REPEAT_EN`.
  - **Defined:** on underrun, retransmit the last successfully consumed pair (`last_pair`, reset value 0).
  - **Undefined:** on underrun, transmit zeros on both channels, and `last_pair` is not built.
- `underrun` pulses in both builds.

## Structure

- Shared package `i2s_pkg` holds:
  - the channel select encoding (`I2S_CH_LEFT`=0, `I2S_CH_RIGHT`=1);
  - the default sample width (16).
- Sub-module `i2s_clk_edge`: registers `sck`/`ws` and outputs `sck_rise`, `sck_fall`, `ws_change` and `ws_q`.

## Test plan

- **Basic serialization.** `WIDTH`=16, 32-`sck` frames, push L=16'hA5C3, R=16'h0F0F. → After the left boundary, `sd` carries 1010_0101_1100_0011 MSB-first starting one `sck` after `ws` falls. The right word is 0000_1111_0000_1111.
- **Pad bits.** `WIDTH`=16, 64-`sck` frames (32 bits per slot), push one pair. → Bits 17–32 of each slot are 0.
- **Short slot.** `WIDTH`=16, 24-`sck` frames (12 bits per slot), L=16'hFFFF. → 12 ones are sent, the word is truncated, and the right word starts on the next `ws` change with no stuck state.
- **Underrun.** Push L=16'h1234, R=16'h5678, then no more data for 2 frames. → `underrun` pulses once per frame, twice in total.
  - `I2S_TX_UNDERRUN_REPEAT_EN` defined: both frames repeat 16'h1234 / 16'h5678.
  - Undefined: both frames are 0.
- **Backpressure.** Hold `input_tvalid`=1 with an incrementing pair. → `input_tready` rises once per frame, one cycle after the left boundary. No pair is lost or duplicated over 8 frames.
- **Reset mid-word.** Drop `rst` low during the left word. → `sd`=0, `input_tready`=1 and `underrun`=0 immediately. After release, the next pushed pair appears at the next left boundary.
